alu_issue_ctrl: RTL and testbench

- Multi-cycle decode/issue controller that drives the datapath ALU's control interface.
- Accepts one 32-bit MIPS-style instruction per transaction over a valid/ready handshake and decodes it to the ALU's 6-bit alu_control, shamt and immediate.
- Sequences the instruction through the ALU, samples the ALU zero flag for branches, and emits register-file and memory strobes.
- Sits between instruction fetch and the ALU/register file.

---
 rtl/alu_issue_ctrl_if.sv | 22 ++
 rtl/alu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction fetch handshake between the fetch stage and alu_issue_ctrl.
//   instr       : 32-bit instruction word, sampled on handshake
//   instr_valid : fetch has an instruction present
//   instr_ready : issue controller can accept an instruction
// master = fetch side, slave = issue controller side.
interface alu_issue_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle decode/issue controller driving the datapath ALU control interface.
//
// One MIPS-style instruction is accepted per transaction and walked through
// IDLE -> DECODE -> EXEC -> WB. Handshake in cycle 0, ALU control stable in
// cycle 2 (EXEC), strobes and done in cycle 3 (WB); one instruction per 4 cycles.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   fetch_if (slave)  : instr / instr_valid / instr_ready handshake
//   alu_zero_i        : ALU zero flag, sampled at the end of EXEC
//   alu_control_o     : 6-bit ALU op code, NOP_CTRL when idle or illegal
//   alu_shamt_o       : instr[10:6]
//   alu_imm_o         : instr[15:0]
//   alu_b_imm_o       : ALU b operand taken from the immediate
//   imm_zext_o        : zero-extend the immediate (ANDI/ORI/XORI)
//   rs_addr_o/rt_addr_o : source register addresses
//   reg_we_o, reg_waddr_o : one-cycle register write strobe and address
//   mem_re_o, mem_we_o    : one-cycle load/store strobes
//   branch_taken_o    : one-cycle pulse, alu_zero sampled in EXEC
//   done_o            : one-cycle completion pulse
//   illegal_o         : one-cycle pulse in DECODE for undecodable instructions
//
// Build option: define ALU_ISSUE_EXT_CMP_EN to make the extended compare
// R-type functs (NOT, SEQ/SNE/SGT/SGTE/SLT/SLEQ/SLEU/SGTU) legal.
module alu_issue_ctrl #(
  parameter logic [5:0] NOP_CTRL = 6'b111111,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_ctrl_if.slave       fetch_if,
  input  logic                  alu_zero_i,
  output logic [5:0]            alu_control_o,
  output logic [4:0]            alu_shamt_o,
  output logic [15:0]           alu_imm_o,
  output logic                  alu_b_imm_o,
  output logic                  imm_zext_o,
  output logic [4:0]            rs_addr_o,
  output logic [4:0]            rt_addr_o,
  output logic                  reg_we_o,
  output logic [4:0]            reg_waddr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic                  branch_taken_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StWb     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q;

  // Registered decode results, loaded at the end of DECODE.
  logic [5:0]  alu_control_q;
  logic [4:0]  alu_shamt_q;
  logic [15:0] alu_imm_q;
  logic        alu_b_imm_q;
  logic        imm_zext_q;
  logic [4:0]  rs_addr_q;
  logic [4:0]  rt_addr_q;
  logic [4:0]  reg_waddr_q;
  logic        reg_we_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic        branch_q;
  logic        zero_q;

  // Instruction fields.
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];

  // Combinational decode of the latched instruction.
  logic [5:0] dec_ctrl;
  logic       dec_b_imm;
  logic       dec_zext;
  logic       dec_reg_we;
  logic       dec_mem_re;
  logic       dec_mem_we;
  logic       dec_branch;
  logic [4:0] dec_waddr;
  logic [4:0] dec_rt;
  logic       dec_illegal;

  always_comb begin
    dec_ctrl    = NOP_CTRL;
    dec_b_imm   = 1'b0;
    dec_zext    = 1'b0;
    dec_reg_we  = 1'b0;
    dec_mem_re  = 1'b0;
    dec_mem_we  = 1'b0;
    dec_branch  = 1'b0;
    dec_waddr   = rt;
    dec_rt      = rt;
    dec_illegal = 1'b0;

    unique case (opcode)
      6'b000000: begin
        dec_ctrl   = funct;
        dec_waddr  = rd;
        dec_reg_we = 1'b1;
        unique case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b000000, 6'b000010, 6'b000011,
          6'b101010, 6'b101011,
          6'b010000, 6'b010010: ;
          // MULT/MULTU/MADD/MADDU only touch Hi/Lo; JR writes nothing.
          6'b011000, 6'b011001, 6'b011100, 6'b011101,
          6'b001000: dec_reg_we = 1'b0;
`ifdef ALU_ISSUE_EXT_CMP_EN
          6'b101000,
          6'b101100, 6'b101101, 6'b101110, 6'b101111,
          6'b110000, 6'b110001, 6'b110010, 6'b110011: ;
`endif
          default: dec_illegal = 1'b1;
        endcase
        // LINK_REG is reserved; an R-type that would write it is rejected.
        if (dec_reg_we && (rd == LINK_REG)) begin
          dec_illegal = 1'b1;
        end
      end
      6'b001000: begin dec_ctrl = 6'b100000; dec_b_imm = 1'b1; dec_reg_we = 1'b1; end
      6'b001001: begin dec_ctrl = 6'b100001; dec_b_imm = 1'b1; dec_reg_we = 1'b1; end
      6'b001010: begin dec_ctrl = 6'b101010; dec_b_imm = 1'b1; dec_reg_we = 1'b1; end
      6'b001011: begin dec_ctrl = 6'b101011; dec_b_imm = 1'b1; dec_reg_we = 1'b1; end
      6'b001100: begin
        dec_ctrl = 6'b100100; dec_b_imm = 1'b1; dec_zext = 1'b1; dec_reg_we = 1'b1;
      end
      6'b001101: begin
        dec_ctrl = 6'b100101; dec_b_imm = 1'b1; dec_zext = 1'b1; dec_reg_we = 1'b1;
      end
      6'b001110: begin
        dec_ctrl = 6'b100110; dec_b_imm = 1'b1; dec_zext = 1'b1; dec_reg_we = 1'b1;
      end
      6'b100011: begin
        dec_ctrl = 6'b100000; dec_b_imm = 1'b1; dec_mem_re = 1'b1; dec_reg_we = 1'b1;
      end
      6'b101011: begin
        dec_ctrl = 6'b100000; dec_b_imm = 1'b1; dec_mem_we = 1'b1;
      end
      6'b000100: begin dec_ctrl = 6'b101100; dec_branch = 1'b1; end
      6'b000101: begin dec_ctrl = 6'b101101; dec_branch = 1'b1; end
      // BLEZ/BGTZ compare rs against $0.
      6'b000110: begin dec_ctrl = 6'b110001; dec_branch = 1'b1; dec_rt = 5'd0; end
      6'b000111: begin dec_ctrl = 6'b101110; dec_branch = 1'b1; dec_rt = 5'd0; end
      default:   dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_ctrl   = NOP_CTRL;
      dec_reg_we = 1'b0;
      dec_mem_re = 1'b0;
      dec_mem_we = 1'b0;
      dec_branch = 1'b0;
    end
  end

  logic handshake;
  assign handshake = fetch_if.instr_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (handshake) state_d = StDecode;
      StDecode: state_d = dec_illegal ? StIdle : StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        instr_q <= fetch_if.instr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_control_q <= NOP_CTRL;
      alu_shamt_q   <= '0;
      alu_imm_q     <= '0;
      alu_b_imm_q   <= 1'b0;
      imm_zext_q    <= 1'b0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      reg_waddr_q   <= '0;
      reg_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      branch_q      <= 1'b0;
      zero_q        <= 1'b0;
    end else begin
      if ((state_q == StDecode) && !dec_illegal) begin
        alu_control_q <= dec_ctrl;
        alu_shamt_q   <= instr_q[10:6];
        alu_imm_q     <= instr_q[15:0];
        alu_b_imm_q   <= dec_b_imm;
        imm_zext_q    <= dec_zext;
        rs_addr_q     <= rs;
        rt_addr_q     <= dec_rt;
        reg_waddr_q   <= dec_waddr;
        reg_we_q      <= dec_reg_we;
        mem_re_q      <= dec_mem_re;
        mem_we_q      <= dec_mem_we;
        branch_q      <= dec_branch;
      end
      if (state_q == StExec) begin
        zero_q <= alu_zero_i;
      end
      if (state_q == StWb) begin
        alu_control_q <= NOP_CTRL;
      end
    end
  end

  logic in_wb;
  assign in_wb = (state_q == StWb);

  assign fetch_if.instr_ready = (state_q == StIdle);

  assign alu_control_o  = alu_control_q;
  assign alu_shamt_o    = alu_shamt_q;
  assign alu_imm_o      = alu_imm_q;
  assign alu_b_imm_o    = alu_b_imm_q;
  assign imm_zext_o     = imm_zext_q;
  assign rs_addr_o      = rs_addr_q;
  assign rt_addr_o      = rt_addr_q;
  assign reg_waddr_o    = reg_waddr_q;
  // Writes to $0 are dropped; the instruction still completes.
  assign reg_we_o       = in_wb && reg_we_q && (reg_waddr_q != 5'd0);
  assign mem_re_o       = in_wb && mem_re_q;
  assign mem_we_o       = in_wb && mem_we_q;
  assign branch_taken_o = in_wb && branch_q && zero_q;
  assign done_o         = in_wb;
  assign illegal_o      = (state_q == StDecode) && dec_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_zero;
  logic [5:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic [15:0] alu_imm;
  logic        alu_b_imm;
  logic        imm_zext;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic        mem_re;
  logic        mem_we;
  logic        branch_taken;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl_if fetch_if ();

  alu_issue_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_if       (fetch_if.slave),
    .alu_zero_i     (alu_zero),
    .alu_control_o  (alu_control),
    .alu_shamt_o    (alu_shamt),
    .alu_imm_o      (alu_imm),
    .alu_b_imm_o    (alu_b_imm),
    .imm_zext_o     (imm_zext),
    .rs_addr_o      (rs_addr),
    .rt_addr_o      (rt_addr),
    .reg_we_o       (reg_we),
    .reg_waddr_o    (reg_waddr),
    .mem_re_o       (mem_re),
    .mem_we_o       (mem_we),
    .branch_taken_o (branch_taken),
    .done_o         (done),
    .illegal_o      (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    fetch_if.instr       = w;
    fetch_if.instr_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [47:0] zeros;
    rst = 1'b1;
    fetch_if.instr_valid = 1'b0;
    fetch_if.instr = '0;
    alu_zero = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    zeros = {alu_shamt, alu_imm, alu_b_imm, imm_zext, rs_addr, rt_addr, reg_we, reg_waddr,
             mem_re, mem_we, branch_taken, done, illegal};
    checks++;
    if (zeros !== 48'd0) begin
      errors++; $display("FAIL reset_zero_outputs: got %h expected 0", zeros);
    end
    checks++;
    if (alu_control !== 6'b111111) begin
      errors++; $display("FAIL reset_alu_control: got %b expected 111111", alu_control);
    end
    checks++;
    if (fetch_if.instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", fetch_if.instr_ready);
    end

    // ADD $3,$1,$2 interrupted by reset in EXEC.
    send(32'h00221820);
    step();
    fetch_if.instr_valid = 1'b0;
    step();
    checks++;
    if (alu_control !== 6'b100000) begin
      errors++; $display("FAIL rst_add_exec_ctrl: got %b expected 100000", alu_control);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_control !== 6'b111111 || fetch_if.instr_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ctrl %b ready %b done %b expected 111111 1 0",
               alu_control, fetch_if.instr_ready, done);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (reg_we !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL rst_dropped_c%0d: reg_we %b done %b expected 0 0", i, reg_we, done);
      end
      step();
    end

    send(32'h00221820);
    step();
    fetch_if.instr_valid = 1'b0;
    step();
    checks++;
    if (alu_control !== 6'b100000 || rs_addr !== 5'd1 || rt_addr !== 5'd2) begin
      errors++;
      $display("FAIL add_exec: ctrl %b rs %0d rt %0d expected 100000 1 2", alu_control, rs_addr, rt_addr);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL add_wb: reg_we %b waddr %0d done %b expected 1 3 1", reg_we, reg_waddr, done);
    end
    step();
    checks++;
    if (alu_control !== 6'b111111 || fetch_if.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_idle: ctrl %b ready %b expected 111111 1", alu_control, fetch_if.instr_ready);
    end
  endtask

  task automatic test_addi();
    send(32'h2005FFFF);
    step();
    fetch_if.instr_valid = 1'b0;
    checks++;
    if (fetch_if.instr_ready !== 1'b0) begin
      errors++; $display("FAIL addi_busy_ready: got %b expected 0", fetch_if.instr_ready);
    end
    step();
    checks++;
    if (alu_control !== 6'b100000 || alu_b_imm !== 1'b1 || imm_zext !== 1'b0 ||
        alu_imm !== 16'hFFFF) begin
      errors++;
      $display("FAIL addi_exec: ctrl %b bimm %b zext %b imm %h expected 100000 1 0 ffff",
               alu_control, alu_b_imm, imm_zext, alu_imm);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd5 || done !== 1'b1 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL addi_wb: reg_we %b waddr %0d done %b mem_re %b expected 1 5 1 0",
               reg_we, reg_waddr, done, mem_re);
    end
    step();
  endtask

  task automatic test_branch();
    // BEQ $1,$2 taken then not taken.
    for (int z = 1; z >= 0; z--) begin
      send(32'h10220004);
      step();
      fetch_if.instr_valid = 1'b0;
      step();
      alu_zero = z[0];
      checks++;
      if (alu_control !== 6'b101100 || alu_b_imm !== 1'b0) begin
        errors++;
        $display("FAIL beq_exec_z%0d: ctrl %b bimm %b expected 101100 0", z, alu_control, alu_b_imm);
      end
      step();
      alu_zero = 1'b0;
      checks++;
      if (branch_taken !== z[0] || reg_we !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL beq_wb_z%0d: taken %b reg_we %b done %b expected %0d 0 1",
                 z, branch_taken, reg_we, done, z);
      end
      step();
    end
    // BLEZ $1 with a nonzero rt field: rt_addr must be forced to 0.
    send(32'h18230008);
    step();
    fetch_if.instr_valid = 1'b0;
    step();
    alu_zero = 1'b1;
    checks++;
    if (alu_control !== 6'b110001 || rt_addr !== 5'd0 || rs_addr !== 5'd1) begin
      errors++;
      $display("FAIL blez_exec: ctrl %b rt %0d rs %0d expected 110001 0 1", alu_control, rt_addr, rs_addr);
    end
    step();
    alu_zero = 1'b0;
    checks++;
    if (branch_taken !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL blez_wb: taken %b done %b expected 1 1", branch_taken, done);
    end
    step();
  endtask

  task automatic test_load_store();
    // LW $4,8($1)
    send(32'h8C240008);
    step();
    fetch_if.instr_valid = 1'b0;
    step();
    checks++;
    if (alu_control !== 6'b100000 || alu_b_imm !== 1'b1) begin
      errors++; $display("FAIL lw_exec: ctrl %b bimm %b expected 100000 1", alu_control, alu_b_imm);
    end
    step();
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || reg_we !== 1'b1 || reg_waddr !== 5'd4) begin
      errors++;
      $display("FAIL lw_wb: re %b we %b reg_we %b waddr %0d expected 1 0 1 4",
               mem_re, mem_we, reg_we, reg_waddr);
    end
    step();
    // SW $4,8($1)
    send(32'hAC240008);
    step();
    fetch_if.instr_valid = 1'b0;
    step();
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || reg_we !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL sw_wb: we %b re %b reg_we %b done %b expected 1 0 0 1",
               mem_we, mem_re, reg_we, done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    send(32'h00220018);  // MULT $1,$2
    step();
    fetch_if.instr = 32'h00001810;  // MFHI $3, valid stays high
    step();
    checks++;
    if (alu_control !== 6'b011000) begin
      errors++; $display("FAIL mult_exec: ctrl %b expected 011000", alu_control);
    end
    step();
    checks++;
    if (reg_we !== 1'b0 || done !== 1'b1 || fetch_if.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mult_wb: reg_we %b done %b ready %b expected 0 1 0",
               reg_we, done, fetch_if.instr_ready);
    end
    step();
    checks++;
    if (fetch_if.instr_ready !== 1'b1 || alu_control !== 6'b111111) begin
      errors++;
      $display("FAIL b2b_c4: ready %b ctrl %b expected 1 111111", fetch_if.instr_ready, alu_control);
    end
    step();
    fetch_if.instr_valid = 1'b0;
    checks++;
    if (fetch_if.instr_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_c5_ready: got %b expected 0", fetch_if.instr_ready);
    end
    step();
    checks++;
    if (alu_control !== 6'b010000) begin
      errors++; $display("FAIL mfhi_exec: ctrl %b expected 010000", alu_control);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL mfhi_wb: reg_we %b waddr %0d done %b expected 1 3 1", reg_we, reg_waddr, done);
    end
    step();
  endtask

  task automatic test_ext_cmp();
    send(32'h0022182C);  // R-type funct 101100
    step();
    fetch_if.instr_valid = 1'b0;
`ifdef ALU_ISSUE_EXT_CMP_EN
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL ext_illegal: got %b expected 0", illegal);
    end
    step();
    checks++;
    if (alu_control !== 6'b101100) begin
      errors++; $display("FAIL ext_exec: ctrl %b expected 101100", alu_control);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL ext_wb: reg_we %b waddr %0d done %b expected 1 3 1", reg_we, reg_waddr, done);
    end
    step();
`else
    checks++;
    if (illegal !== 1'b1 || alu_control !== 6'b111111 || done !== 1'b0) begin
      errors++;
      $display("FAIL ext_illegal: illegal %b ctrl %b done %b expected 1 111111 0",
               illegal, alu_control, done);
    end
    step();
    checks++;
    if (illegal !== 1'b0 || fetch_if.instr_ready !== 1'b1 || done !== 1'b0 ||
        alu_control !== 6'b111111) begin
      errors++;
      $display("FAIL ext_after: illegal %b ready %b done %b ctrl %b expected 0 1 0 111111",
               illegal, fetch_if.instr_ready, done, alu_control);
    end
    step();
    checks++;
    if (done !== 1'b0 || reg_we !== 1'b0) begin
      errors++; $display("FAIL ext_no_done: done %b reg_we %b expected 0 0", done, reg_we);
    end
`endif
  endtask

  task automatic test_link_reg();
    send(32'h0022F820);  // ADD $31,$1,$2
    step();
    fetch_if.instr_valid = 1'b0;
    checks++;
    if (illegal !== 1'b1) begin
      errors++; $display("FAIL link_reg_illegal: got %b expected 1", illegal);
    end
    step();
    step();
    checks++;
    if (done !== 1'b0 || reg_we !== 1'b0) begin
      errors++; $display("FAIL link_reg_no_wb: done %b reg_we %b expected 0 0", done, reg_we);
    end
  endtask

  task automatic test_ori_zero();
    send(32'h3400FFFF);  // ORI $0,$0,0xFFFF
    step();
    fetch_if.instr_valid = 1'b0;
    step();
    checks++;
    if (alu_control !== 6'b100101 || imm_zext !== 1'b1 || alu_b_imm !== 1'b1) begin
      errors++;
      $display("FAIL ori_exec: ctrl %b zext %b bimm %b expected 100101 1 1",
               alu_control, imm_zext, alu_b_imm);
    end
    step();
    checks++;
    if (reg_we !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL ori_wb: reg_we %b done %b expected 0 1", reg_we, done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_load_store();
    test_back_to_back();
    test_ext_cmp();
    test_link_reg();
    test_ori_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
